// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the fetch PC, drives a 1-cycle-latency instruction ROM and
// buffers returned instructions in a small queue that feeds decode via valid/ready.
module fetch_prefetch_unit #(
   parameter int INST_W = 26,
   parameter int PC_W = 32,
   parameter int DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_en,
   output logic [PC_W-1:0]          rom_addr,
   input  logic [INST_W-1:0]        rom_q,
   input  logic                     redirect,
   input  logic [PC_W-1:0]          redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INST_W-1:0]        out_inst,
   output logic [PC_W-1:0]          out_pc,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0]   r_fetchPc;
   logic              r_inflight;
   logic [PC_W-1:0]   r_inflightPc;
   logic [AW-1:0]     r_rdPtr;
   logic [AW-1:0]     r_wrPtr;
   logic [CW-1:0]     r_count;
   logic [INST_W-1:0] r_qInst [DEPTH];
   logic [PC_W-1:0]   r_qPc   [DEPTH];

   logic              w_credit;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;

   // An in-flight request already owns a slot, so the credit check counts it;
   // same-cycle pops are ignored to keep the check a short path.
   assign w_credit = (({1'b0, r_count} + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH));
   assign w_issue  = fetch_en & ~redirect & w_credit;
   assign w_push   = r_inflight & ~redirect;
   assign w_pop    = out_valid & out_ready & ~redirect;

   assign rom_addr  = r_fetchPc;
   assign out_valid = (r_count != '0);
   assign out_inst  = r_qInst[r_rdPtr];
   assign out_pc    = r_qPc[r_rdPtr];
   assign q_count   = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetchPc    <= RESET_PC;
         r_inflight   <= 1'b0;
         r_inflightPc <= '0;
      end else if (redirect) begin
         r_fetchPc    <= redirect_pc;
         r_inflight   <= 1'b0;
      end else if (w_issue) begin
         r_fetchPc    <= r_fetchPc + PC_W'(1);
         r_inflight   <= 1'b1;
         r_inflightPc <= r_fetchPc;
      end else begin
         r_inflight   <= 1'b0;
      end
   end

   // Redirect flushes by zeroing occupancy and pointers; stale entries are
   // never exposed because out_valid follows the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (redirect) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_qInst[i] <= '0;
            r_qPc[i]   <= '0;
         end
      end else if (w_push) begin
         r_qInst[r_wrPtr] <= rom_q;
         r_qPc[r_wrPtr]   <= r_inflightPc;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a behavioural ROM with ROM[i] = i + 0x100
// and hand-derived cycle-by-cycle expectations for each scenario.
module tb_fetch_prefetch_unit;

   logic        clk;
   logic        rst;
   logic        fetchEn;
   logic [31:0] romAddr;
   logic [25:0] romQ;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        outValid;
   logic        outReady;
   logic [25:0] outInst;
   logic [31:0] outPc;
   logic [2:0]  qCount;

   int total;
   int bad;

   fetch_prefetch_unit #(
      .INST_W(26), .PC_W(32), .DEPTH(4), .RESET_PC(32'd0)
   ) dut (
      .clk(clk), .rst(rst), .fetch_en(fetchEn), .rom_addr(romAddr), .rom_q(romQ),
      .redirect(redirect), .redirect_pc(redirectPc), .out_valid(outValid),
      .out_ready(outReady), .out_inst(outInst), .out_pc(outPc), .q_count(qCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [25:0] romData(input logic [31:0] pc);
      logic [31:0] s;
      s = pc + 32'h100;
      return s[25:0];
   endfunction

   // Synchronous ROM with one cycle of read latency.
   always @(posedge clk) romQ <= romData(romAddr);

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic ready, input logic redir, input logic [31:0] rpc);
      fetchEn    = en;
      outReady   = ready;
      redirect   = redir;
      redirectPc = rpc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0: the first cycle after reset deasserts.
   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Checks that PCs startPc.. are delivered in order with matching instructions.
   task automatic expectStream(input string tag, input logic [31:0] startPc, input int n, input int budget);
      int got;
      int cyc;
      logic [31:0] expPc;
      got = 0;
      cyc = 0;
      expPc = startPc;
      while (got < n && cyc < budget) begin
         if (outValid && outReady) begin
            checkOutput({tag, "_pc"}, 64'(outPc), 64'(expPc));
            checkOutput({tag, "_inst"}, 64'(outInst), 64'(romData(expPc)));
            expPc = expPc + 32'd1;
            got++;
         end
         step();
         cyc++;
      end
      checkOutput({tag, "_delivered"}, 64'(got), 64'(n));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

      // Reset values and first-fetch latency.
      #2;
      checkOutput("rst_valid", 64'(outValid), 64'd0);
      checkOutput("rst_count", 64'(qCount), 64'd0);
      checkOutput("rst_inst", 64'(outInst), 64'd0);
      checkOutput("rst_pc", 64'(outPc), 64'd0);
      checkOutput("rst_addr", 64'(romAddr), 64'd0);
      doReset();
      checkOutput("c0_addr", 64'(romAddr), 64'd0);
      checkOutput("c0_valid", 64'(outValid), 64'd0);
      step();
      checkOutput("c1_addr", 64'(romAddr), 64'd1);
      checkOutput("c1_valid", 64'(outValid), 64'd0);
      step();
      checkOutput("c2_addr", 64'(romAddr), 64'd2);
      checkOutput("c2_valid", 64'(outValid), 64'd1);
      checkOutput("c2_pc", 64'(outPc), 64'd0);
      checkOutput("c2_inst", 64'(outInst), 64'h100);
      for (int k = 1; k <= 5; k++) begin
         step();
         checkOutput("steady_valid", 64'(outValid), 64'd1);
         checkOutput("steady_pc", 64'(outPc), 64'(k));
         checkOutput("steady_addr", 64'(romAddr), 64'(k + 2));
      end

      // Backpressure from cycle 2 fills the queue and stops issue at PC 4.
      doReset();
      step();
      step();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      step();
      step();
      step();
      step();
      checkOutput("bp_count", 64'(qCount), 64'd4);
      checkOutput("bp_addr", 64'(romAddr), 64'd4);
      checkOutput("bp_pc", 64'(outPc), 64'd0);
      step();
      checkOutput("bp_addr_hold", 64'(romAddr), 64'd4);
      checkOutput("bp_pc_hold", 64'(outPc), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      expectStream("bp_stream", 32'd0, 8, 40);

      // Redirect at cycle 5 with two entries queued.
      doReset();
      step();
      step();
      step();
      step();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      step();
      checkOutput("rd_count_c5", 64'(qCount), 64'd2);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
      step();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("rd_c6_valid", 64'(outValid), 64'd0);
      checkOutput("rd_c6_count", 64'(qCount), 64'd0);
      checkOutput("rd_c6_addr", 64'(romAddr), 64'h40);
      step();
      checkOutput("rd_c7_valid", 64'(outValid), 64'd0);
      step();
      checkOutput("rd_c8_valid", 64'(outValid), 64'd1);
      checkOutput("rd_c8_pc", 64'(outPc), 64'h40);
      checkOutput("rd_c8_inst", 64'(outInst), 64'h140);
      step();
      checkOutput("rd_c9_pc", 64'(outPc), 64'h41);
      checkOutput("rd_c9_valid", 64'(outValid), 64'd1);

      // Redirect coinciding with a pop, then held for three cycles.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
      step();
      checkOutput("rh_t1_valid", 64'(outValid), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h90);
      step();
      checkOutput("rh_t2_valid", 64'(outValid), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hA0);
      step();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("rh_t3_valid", 64'(outValid), 64'd0);
      checkOutput("rh_t3_addr", 64'(romAddr), 64'hA0);
      step();
      checkOutput("rh_t4_valid", 64'(outValid), 64'd0);
      step();
      checkOutput("rh_t5_valid", 64'(outValid), 64'd1);
      checkOutput("rh_t5_pc", 64'(outPc), 64'hA0);
      checkOutput("rh_t5_inst", 64'(outInst), 64'h1A0);
      step();
      checkOutput("rh_t6_pc", 64'(outPc), 64'hA1);

      // fetch_en low for five cycles: in-flight PC 2 still arrives, no issue.
      doReset();
      step();
      step();
      step();
      checkOutput("fe_c3_addr", 64'(romAddr), 64'd3);
      checkOutput("fe_c3_pc", 64'(outPc), 64'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      step();
      checkOutput("fe_c4_addr", 64'(romAddr), 64'd3);
      checkOutput("fe_c4_valid", 64'(outValid), 64'd1);
      checkOutput("fe_c4_pc", 64'(outPc), 64'd2);
      step();
      checkOutput("fe_c5_addr", 64'(romAddr), 64'd3);
      checkOutput("fe_c5_valid", 64'(outValid), 64'd0);
      step();
      checkOutput("fe_c6_addr", 64'(romAddr), 64'd3);
      step();
      checkOutput("fe_c7_addr", 64'(romAddr), 64'd3);
      checkOutput("fe_c7_valid", 64'(outValid), 64'd0);
      step();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("fe_c8_addr", 64'(romAddr), 64'd3);
      step();
      checkOutput("fe_c9_valid", 64'(outValid), 64'd0);
      step();
      checkOutput("fe_c10_pc", 64'(outPc), 64'd3);
      checkOutput("fe_c10_inst", 64'(outInst), 64'h103);
      step();
      checkOutput("fe_c11_pc", 64'(outPc), 64'd4);

      // Async reset pulse with a full queue, checked between clock edges.
      doReset();
      step();
      step();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      step();
      step();
      step();
      step();
      checkOutput("ar_full", 64'(qCount), 64'd4);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_valid", 64'(outValid), 64'd0);
      checkOutput("ar_count", 64'(qCount), 64'd0);
      checkOutput("ar_addr", 64'(romAddr), 64'd0);
      checkOutput("ar_pc", 64'(outPc), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expectStream("ar_restart", 32'd0, 3, 10);

      // PC wraps from all-ones to zero.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      step();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("wr_addr", 64'(romAddr), 64'hFFFF_FFFF);
      step();
      checkOutput("wr_addr_next", 64'(romAddr), 64'd0);
      step();
      checkOutput("wr_pc_top", 64'(outPc), 64'hFFFF_FFFF);
      checkOutput("wr_inst_top", 64'(outInst), 64'h0FF);
      step();
      checkOutput("wr_pc_zero", 64'(outPc), 64'd0);
      checkOutput("wr_inst_zero", 64'(outInst), 64'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the synchronous instruction ROM, which has 1-cycle read latency.
- Holds returned instructions in a small prefetch queue and presents them to decode with a valid/ready handshake.
- Decode can stall via ready. Execute can redirect via redirect/redirect_pc, which flushes the queue and any in-flight fetch.

Parameters:
- INST_W, 26, instruction width.
- PC_W, 32, PC width. The ROM is word-addressed, so the PC advances by 1 per instruction.
- DEPTH, 4, prefetch queue entries. Must be a power of 2 and at least 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  allows new ROM requests; 0 halts issue.
- rom_addr  out  PC_W  ROM address; equals the fetch_pc register.
- rom_q  in  INST_W  ROM data; valid the cycle after the address is presented.
- redirect  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  PC_W  new fetch address, sampled when redirect=1.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  INST_W  head instruction.
- out_pc  out  PC_W  PC of the head instruction.
- q_count  out  clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC; queue empty (rd_ptr = wr_ptr = 0, count = 0); inflight = 0.
  - out_valid = 0, out_inst = 0, out_pc = 0, q_count = 0.
- Issue condition: issue = fetch_en & !redirect & (count + inflight < DEPTH).
  - Pops in the same cycle are not counted; the check is deliberately conservative.
  - On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 1 (wraps modulo 2^PC_W).
  - Otherwise inflight <= 0 and fetch_pc holds.
- Capture: when inflight = 1 and redirect = 0, {rom_q, inflight_pc} is written to queue[wr_ptr] at the next edge and wr_ptr increments.
- Pop: pop = out_valid & out_ready. On pop, rd_ptr increments.
- Occupancy: push and pop in the same cycle leave count unchanged. Overflow is impossible by the credit rule; underflow is impossible because pop requires out_valid.
- Outputs:
  - out_valid = (count != 0).
  - out_inst / out_pc are combinational reads of queue[rd_ptr].
  - out_inst / out_pc hold stable while out_valid = 1 and out_ready = 0.
- Pointers: rd_ptr and wr_ptr wrap modulo DEPTH.
- Latency: first issue is in the cycle after reset deasserts (cycle 0). The instruction is captured at the end of cycle 1, and out_valid = 1 in cycle 2.
- Throughput: with out_ready held at 1, one instruction per cycle in steady state.
- Redirect (cycle t), which takes priority over issue, capture and pop:
  - Queue cleared, inflight cleared (the in-flight response is discarded), fetch_pc <= redirect_pc.
  - A pop in cycle t has no further effect.
  - redirect_pc is issued in t+1; out_valid = 0 in t+1 and t+2; its instruction is valid in t+3.
- Redirect held for several cycles: each cycle re-flushes and reloads fetch_pc.
- fetch_en = 0: no new issues. A pending inflight response is still captured and the queue still drains. Resuming continues from the held fetch_pc.
- Reset mid-operation: all state returns to reset values immediately, regardless of inflight, queue contents or redirect.

Test Plan:
- Reset release with fetch_en = 1, out_ready = 1, ROM[i] = i+0x100:
  - rom_addr = 0, 1, 2, … in cycles 0, 1, 2, …
  - out_valid first high in cycle 2 with out_pc = 0, out_inst = 0x100.
  - Then one instruction per cycle, PCs consecutive.
- Backpressure: out_ready = 0 from cycle 2:
  - q_count rises to 4 and issue stops (rom_addr holds at 4).
  - out_pc stays 0. After release, PCs 0..7 are delivered in order with no gap or duplicate.
- Redirect at cycle 5 to 0x40 with 2 entries queued:
  - out_valid = 0 in cycles 6–7.
  - Cycle 8: out_pc = 0x40, out_inst = ROM[0x40]. No stale PC ever appears.
- Redirect in the same cycle as a pop, and redirect held 3 cycles:
  - Only the last redirect_pc is delivered, 3 cycles after redirect drops.
- fetch_en deasserted for 5 cycles:
  - The in-flight instruction is still delivered; no ROM issue occurs during the halt.
  - Sequence resumes at the correct next PC.
- Async reset pulse mid-stream with a full queue:
  - out_valid and q_count drop to 0 without a clock edge.
  - Restart at RESET_PC.
- PC wrap:
  - redirect_pc = 0xFFFFFFFF yields out_pc 0xFFFFFFFF then 0x00000000.
